gate_sequencer: RTL and testbench



---
 rtl/gate_sequencer.sv | 162 ++++++++++++++++
 tb/tb_gate_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sequencer.sv
// gate_sequencer: drives the gate of gate_buffer. After an accepted start it
// waits D cycles, then opens N windows of W cycles spaced P_eff = max(P, W+1)
// apart. Reports busy/done and the number of completed windows.
// Optional macro GATE_SEQUENCER_PEAK_EN adds capture of the peak sample seen
// while the gate is open; without it o_peak is tied to 0.
module gate_sequencer #(
  parameter int DATA_SIZE  = 14,
  parameter int COUNT_SIZE = 16,
  parameter int BURST_SIZE = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [COUNT_SIZE-1:0] i_delay,
  input  logic [COUNT_SIZE-1:0] i_width,
  input  logic [COUNT_SIZE-1:0] i_period,
  input  logic [BURST_SIZE-1:0] i_bursts,
  input  logic [DATA_SIZE-1:0]  i_data,
  output logic                  o_gate,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [BURST_SIZE-1:0] o_window_count,
  output logic [DATA_SIZE-1:0]  o_peak
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_OPEN, S_GAP} state_t;

  state_t                r_state, w_next;
  logic [COUNT_SIZE-1:0] r_cnt, w_cnt_next;
  logic [COUNT_SIZE-1:0] r_width_m1;   // window length minus one
  logic [COUNT_SIZE-1:0] r_gap_m1;     // low cycles between windows minus one
  logic [BURST_SIZE-1:0] r_bursts;
  logic                  r_empty;      // W==0 or N==0: sequence with no window
  logic [BURST_SIZE-1:0] r_wc, w_wc_next, w_wc_inc;
  logic                  r_gate, r_busy, r_done;
  logic                  w_done_next;
  logic                  w_latch;

  // P_eff is formed one bit wider so W = all-ones does not wrap W+1.
  logic [COUNT_SIZE:0] w_wp1, w_peff, w_gap_full;
  assign w_wp1      = {1'b0, i_width} + (COUNT_SIZE+1)'(1);
  assign w_peff     = ({1'b0, i_period} > w_wp1) ? {1'b0, i_period} : w_wp1;
  assign w_gap_full = w_peff - {1'b0, i_width} - (COUNT_SIZE+1)'(1);
  assign w_wc_inc   = r_wc + BURST_SIZE'(1);

  // Next-state logic; DELAY spends D+1 cycles so D==0 opens the gate after E0+1.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    w_wc_next   = r_wc;
    w_done_next = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_next     = S_DELAY;
          w_cnt_next = i_delay;
          w_wc_next  = '0;
          w_latch    = 1'b1;
        end
      end
      S_DELAY: begin
        if (r_empty) begin
          w_next      = S_IDLE;
          w_done_next = 1'b1;
        end else if (r_cnt == '0) begin
          w_next     = S_OPEN;
          w_cnt_next = r_width_m1;
        end else begin
          w_cnt_next = r_cnt - COUNT_SIZE'(1);
        end
      end
      S_OPEN: begin
        if (r_cnt == '0) begin
          w_wc_next = w_wc_inc;
          if (w_wc_inc == r_bursts) begin
            w_next      = S_IDLE;
            w_done_next = 1'b1;
          end else begin
            w_next     = S_GAP;
            w_cnt_next = r_gap_m1;
          end
        end else begin
          w_cnt_next = r_cnt - COUNT_SIZE'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_next     = S_OPEN;
          w_cnt_next = r_width_m1;
        end else begin
          w_cnt_next = r_cnt - COUNT_SIZE'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Abort beats window end and completion; completed windows are kept.
    if (i_abort && r_state != S_IDLE) begin
      w_next      = S_IDLE;
      w_wc_next   = r_wc;
      w_done_next = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wc    <= '0;
      r_gate  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_wc    <= w_wc_next;
      r_gate  <= (w_next == S_OPEN);
      r_busy  <= (w_next != S_IDLE);
      r_done  <= w_done_next;
    end
  end

  // Configuration is captured only at the accepted start edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_width_m1 <= '0;
      r_gap_m1   <= '0;
      r_bursts   <= '0;
      r_empty    <= 1'b0;
    end else if (w_latch) begin
      r_width_m1 <= i_width - COUNT_SIZE'(1);
      r_gap_m1   <= w_gap_full[COUNT_SIZE-1:0];
      r_bursts   <= i_bursts;
      r_empty    <= (i_width == '0) || (i_bursts == '0);
    end
  end

  assign o_gate         = r_gate;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_window_count = r_wc;

`ifdef GATE_SEQUENCER_PEAK_EN
  logic [DATA_SIZE-1:0] r_peak;

  // Running unsigned maximum of samples taken while the gate is open.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                       r_peak <= '0;
    else if (w_latch)                  r_peak <= '0;
    else if (r_gate && i_data > r_peak) r_peak <= i_data;
  end

  assign o_peak = r_peak;
`else
  logic w_unused_data;
  assign w_unused_data = ^i_data;
  assign o_peak        = '0;
`endif

endmodule

// File: tb/tb_gate_sequencer.sv
// Self-checking bench for gate_sequencer. The reference model derives every
// cycle's expected outputs directly from the timing formulas (window index and
// phase from arithmetic on the cycle offset), not from a state machine.
module tb_gate_sequencer;
  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [15:0] i_delay = '0, i_width = '0, i_period = '0;
  logic [7:0]  i_bursts = '0;
  logic [13:0] i_data = '0;
  logic        o_gate, o_busy, o_done;
  logic [7:0]  o_window_count;
  logic [13:0] o_peak;

  int checks = 0;
  int errors = 0;
  int m_wc   = 0;   // window count held from the last sequence
  int m_peak = 0;   // peak held from the last sequence

  gate_sequencer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_delay(i_delay), .i_width(i_width), .i_period(i_period), .i_bursts(i_bursts),
    .i_data(i_data), .o_gate(o_gate), .o_busy(o_busy), .o_done(o_done),
    .o_window_count(o_window_count), .o_peak(o_peak)
  );

  always #5 i_clock = ~i_clock;

  function automatic int exp_peak_of(input int p);
`ifdef GATE_SEQUENCER_PEAK_EN
    return p;
`else
    return 0 * p;
`endif
  endfunction

  // Expected outputs after edge E0+k; stop = abort edge (0 = none).
  function automatic void model(input int d, w, n, peff, fin, stop, k,
                                output bit g, output bit b, output bit dn,
                                output int wc);
    bit empty;
    int lim, j;
    empty = (w == 0) || (n == 0);
    lim   = (stop != 0 && k >= stop) ? stop - 1 : k;
    wc    = 0;
    if (!empty)
      for (int i = 0; i < n; i++)
        if (d + 1 + i * peff + w <= lim) wc++;
    g = 0; b = 0; dn = 0;
    if (!(stop != 0 && k >= stop)) begin
      b  = (k < fin);
      dn = (k == fin);
      if (!empty && k >= d + 1) begin
        j = k - d - 1;
        g = (j / peff < n) && (j % peff < w);
      end
    end
  endfunction

  // Runs one sequence from just after a negedge; returns just after the
  // negedge following its final edge (the done cycle on normal completion).
  task automatic run_seq(input string name, input int d, w, p, n, ab, input bit directed);
    int peff, fin, stop, last, prev_data, ewc, pidx;
    bit eg, eb, ed, prev_gate;
    int pat[3];
    pat[0] = 4000; pat[1] = 1111; pat[2] = 8192;
    pidx = 0;
    peff = (p > w + 1) ? p : w + 1;
    fin  = (w == 0 || n == 0) ? 1 : d + 1 + (n - 1) * peff + w;
    stop = (ab > 0 && ab <= fin) ? ab : 0;
    last = (stop != 0) ? stop : fin;
    i_delay = 16'(d); i_width = 16'(w); i_period = 16'(p); i_bursts = 8'(n);
    i_start = 1'b1; i_abort = 1'b0;
    i_data = directed ? 14'd9999 : 14'($urandom_range(0, 16383));
    prev_data = int'(i_data); prev_gate = 0;
    @(posedge i_clock);
    m_peak = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge i_clock);
      if (k > 0 && prev_gate && prev_data > m_peak) m_peak = prev_data;
      model(d, w, n, peff, fin, stop, k, eg, eb, ed, ewc);
      checks += 5;
      if (o_gate !== eg) begin
        errors++; $display("FAIL %s k=%0d gate got %0b exp %0b", name, k, o_gate, eg);
      end
      if (o_busy !== eb) begin
        errors++; $display("FAIL %s k=%0d busy got %0b exp %0b", name, k, o_busy, eb);
      end
      if (o_done !== ed) begin
        errors++; $display("FAIL %s k=%0d done got %0b exp %0b", name, k, o_done, ed);
      end
      if (int'(o_window_count) != ewc) begin
        errors++; $display("FAIL %s k=%0d wcount got %0d exp %0d", name, k, o_window_count, ewc);
      end
      if (int'(o_peak) != exp_peak_of(m_peak)) begin
        errors++; $display("FAIL %s k=%0d peak got %0d exp %0d", name, k, o_peak, exp_peak_of(m_peak));
      end
      m_wc = ewc;
      prev_gate = eg;
      // drive stimulus for edge k+1
      i_start = 1'b0;
      i_abort = (stop != 0 && k + 1 == stop);
      if (k < last) begin
        i_delay = 16'($urandom); i_width = 16'($urandom); i_period = 16'($urandom);
        i_bursts = 8'($urandom);
        if (eb && $urandom_range(0, 3) == 0) i_start = 1'b1;
      end
      if (directed) begin
        if (eg) begin i_data = 14'(pat[pidx % 3]); pidx++; end
        else i_data = 14'd9999;
      end else begin
        i_data = 14'($urandom_range(0, 16383));
      end
      prev_data = int'(i_data);
    end
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  task automatic idle_cycles(input string name, input int cycles, input bit st, input bit ab);
    for (int c = 0; c < cycles; c++) begin
      i_start = st; i_abort = ab; i_data = 14'($urandom_range(0, 16383));
      @(negedge i_clock);
      checks += 4;
      if (o_busy !== 1'b0 || o_gate !== 1'b0 || o_done !== 1'b0) begin
        errors++; $display("FAIL %s idle gate/busy/done got %0b%0b%0b exp 000", name, o_gate, o_busy, o_done);
      end
      if (int'(o_window_count) != m_wc) begin
        errors++; $display("FAIL %s idle wcount got %0d exp %0d", name, o_window_count, m_wc);
      end
      if (int'(o_peak) != exp_peak_of(m_peak)) begin
        errors++; $display("FAIL %s idle peak got %0d exp %0d", name, o_peak, exp_peak_of(m_peak));
      end
      checks--;   // three comparisons above, four counted minus one
    end
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    checks++;
    if ({o_gate, o_busy, o_done, o_window_count, o_peak} !== '0) begin
      errors++; $display("FAIL reset outputs got %0b %0b %0b %0d %0d exp all 0", o_gate, o_busy, o_done, o_window_count, o_peak);
    end
    i_reset = 1'b0;
    m_wc = 0; m_peak = 0;
    idle_cycles("reset_idle", 2, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    run_seq("basic", 3, 4, 10, 2, 0, 1'b0);
    idle_cycles("basic_hold", 3, 1'b0, 1'b0);
  endtask

  task automatic test_boundaries();
    run_seq("d0_w1_p1", 0, 1, 1, 3, 0, 1'b0);
    idle_cycles("gap1", 1, 1'b0, 1'b0);
    run_seq("w0", 5, 0, 7, 3, 0, 1'b0);
    idle_cycles("gap2", 1, 1'b0, 1'b0);
    run_seq("n0", 2, 4, 6, 0, 0, 1'b0);
    idle_cycles("gap3", 1, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_seq("abort_win2", 3, 4, 10, 2, 16, 1'b0);
    idle_cycles("abort_hold", 2, 1'b0, 1'b0);
    run_seq("abort_at_done", 3, 4, 10, 2, 18, 1'b0);
    idle_cycles("abort_hold2", 2, 1'b0, 1'b0);
    run_seq("abort_delay", 5, 3, 4, 2, 2, 1'b0);
    idle_cycles("abort_hold3", 1, 1'b0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    idle_cycles("start_abort_idle", 4, 1'b1, 1'b1);
    idle_cycles("after_sa", 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq("b2b_a", 2, 3, 5, 2, 0, 1'b0);
    run_seq("b2b_b", 1, 2, 0, 2, 0, 1'b0);
    run_seq("b2b_c", 0, 1, 0, 1, 0, 1'b0);
    idle_cycles("b2b_hold", 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    i_delay = 16'd2; i_width = 16'd5; i_period = 16'd8; i_bursts = 8'd2; i_start = 1'b1;
    @(posedge i_clock);
    @(negedge i_clock); i_start = 1'b0;
    repeat (4) @(negedge i_clock);
    checks++;
    if (o_gate !== 1'b1) begin
      errors++; $display("FAIL reset_mid pre gate got %0b exp 1", o_gate);
    end
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_gate, o_busy, o_done, o_window_count, o_peak} !== '0) begin
      errors++; $display("FAIL reset_mid outputs got %0b %0b %0b %0d %0d exp all 0", o_gate, o_busy, o_done, o_window_count, o_peak);
    end
    @(negedge i_clock); i_reset = 1'b0;
    m_wc = 0; m_peak = 0;
    run_seq("after_reset", 1, 2, 4, 2, 0, 1'b0);
    idle_cycles("after_reset_hold", 1, 1'b0, 1'b0);
  endtask

  task automatic test_peak();
    run_seq("peak", 1, 3, 6, 1, 0, 1'b1);
    idle_cycles("peak_hold", 2, 1'b0, 1'b0);
    checks++;
`ifdef GATE_SEQUENCER_PEAK_EN
    if (o_peak !== 14'd8192) begin
      errors++; $display("FAIL peak_final got %0d exp 8192", o_peak);
    end
`else
    if (o_peak !== 14'd0) begin
      errors++; $display("FAIL peak_final got %0d exp 0", o_peak);
    end
`endif
  endtask

  task automatic test_random();
    int d, w, p, n, ab;
    for (int s = 0; s < 25; s++) begin
      d  = $urandom_range(0, 12);
      w  = $urandom_range(0, 8);
      p  = $urandom_range(0, 15);
      n  = $urandom_range(0, 4);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
      run_seq("random", d, w, p, n, ab, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycles("random_idle", $urandom_range(1, 3), 1'b0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    test_reset_mid();
    test_peak();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
